// File: rtl/clk_period_meter.sv
// clk_period_meter
//
// Measures the period and high time of a slow, asynchronous signal (divided clock, off-chip
// oscillator) in cycles of the fast system clock, and flags loss of signal via a timeout.
//
// Ports:
//   clk_in      system clock, all logic on its rising edge
//   rst         asynchronous reset, active-high
//   sig_in      asynchronous signal to measure
//   period_out  cycles between the last two detected rising edges of sig_in
//   high_out    cycles from rising to falling edge within that period
//   valid       one-cycle pulse when period_out / high_out update
//   no_signal   high while no valid measurement is in progress (reset or timeout)
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on sig_in, 2..4
//   CNT_WIDTH    width of the cycle counter and result outputs
//   TIMEOUT      max cycles between rises before no_signal is raised, 2..2^CNT_WIDTH-1

module clk_period_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned TIMEOUT     = 16777215
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out,
  output logic                 valid,
  output logic                 no_signal
);

  localparam logic [CNT_WIDTH-1:0] TimeoutVal = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StWaitLow,
    StArm,
    StMeasure
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   s_sync;
  logic                   s_prev;
  logic                   primed;
  logic                   rise;
  logic                   fall;

  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   hi_reg;

  // Datapath controls decoded from the FSM.
  logic cnt_start;
  logic cnt_inc;
  logic hi_load;
  logic meas_done;
  logic meas_abort;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prime_q <= '0;
      s_prev  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      s_prev  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_prev;
  assign fall   = ~s_sync & s_prev;

  // The chain comes out of reset holding zeros that were never sampled from sig_in. Until
  // sig_in has propagated through every stage, a low s_sync means nothing; without this, a
  // signal already high at reset release would look like low-then-rise and arm spuriously.
  assign primed = prime_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= StWaitLow;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLow: begin
        if (primed && !s_sync) begin
          state_d = StArm;
        end
      end
      StArm: begin
        if (rise) begin
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        // A rise in the timeout cycle still counts as a valid period.
        if (!rise && (cnt == TimeoutVal)) begin
          state_d = StWaitLow;
        end
      end
      default: state_d = StWaitLow;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (datapath controls)
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_start  = 1'b0;
    cnt_inc    = 1'b0;
    hi_load    = 1'b0;
    meas_done  = 1'b0;
    meas_abort = 1'b0;
    unique case (state_q)
      StArm: begin
        cnt_start = rise;
      end
      StMeasure: begin
        if (rise) begin
          cnt_start = 1'b1;
          meas_done = 1'b1;
        end else begin
          hi_load = fall;
          // Saturating at TIMEOUT is what guarantees the counter never wraps.
          if (cnt == TimeoutVal) begin
            meas_abort = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: counter, high-time capture, result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      hi_reg     <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      no_signal  <= 1'b1;
    end else begin
      valid <= meas_done;

      // cnt is 1 in the cycle after a rise, so at the next rise it equals the period.
      if (cnt_start) begin
        cnt <= CntOne;
      end else if (cnt_inc) begin
        cnt <= cnt + CntOne;
      end

      if (hi_load) begin
        hi_reg <= cnt;
      end

      if (meas_done) begin
        period_out <= cnt;
        high_out   <= hi_reg;
        no_signal  <= 1'b0;
      end else if (meas_abort) begin
        period_out <= '0;
        high_out   <= '0;
        no_signal  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (SYNC_STAGES=2, CNT_WIDTH=24, TIMEOUT=100).
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.

module tb_clk_period_meter;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned CntWidth   = 24;
  localparam int unsigned Timeout    = 100;

  logic                clk_in;
  logic                rst;
  logic                sig_in;
  logic [CntWidth-1:0] period_out;
  logic [CntWidth-1:0] high_out;
  logic                valid;
  logic                no_signal;

  int checks   = 0;
  int failures = 0;

  int cyc        = 0;
  int vcount     = 0;
  int first_vcyc = 0;
  int last_p     = 0;
  int last_h     = 0;
  int base       = 0;
  int rl         = 0;

  clk_period_meter #(
    .SYNC_STAGES(SyncStages),
    .CNT_WIDTH  (CntWidth),
    .TIMEOUT    (Timeout)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sig_in    (sig_in),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .no_signal (no_signal)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: apply sig_in, clock, then record any valid pulse.
  task automatic step(input logic s);
    sig_in = s;
    @(posedge clk_in);
    #1;
    cyc++;
    if (valid) begin
      vcount++;
      last_p = int'(period_out);
      last_h = int'(high_out);
      if (first_vcyc == 0) first_vcyc = cyc;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
    end
  endtask

  task automatic clear_mon();
    vcount     = 0;
    first_vcyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;

    // Reset held while sig_in toggles.
    for (int i = 0; i < 6; i++) begin
      step(i[0]);
      check_eq("rst_period", int'(period_out), 0);
      check_eq("rst_high", int'(high_out), 0);
      check_eq("rst_valid", int'(valid), 0);
      check_eq("rst_nosig", int'(no_signal), 1);
    end

    // Square wave 10/5: first rise arms, later rises report.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0);
    clear_mon();
    base = cyc + 1;
    wave(5, 5, 4);
    check_eq("sq_vcount", vcount, 3);
    check_eq("sq_first_valid_cyc", first_vcyc, base + 10 + SyncStages);
    check_eq("sq_period", last_p, 10);
    check_eq("sq_high", last_h, 5);
    check_eq("sq_nosig", int'(no_signal), 0);

    // Duty 3/7, then 20/30.
    clear_mon();
    wave(3, 7, 3);
    check_eq("duty37_vcount", vcount, 3);
    check_eq("duty37_period", last_p, 10);
    check_eq("duty37_high", last_h, 3);
    clear_mon();
    wave(20, 30, 2);
    check_eq("duty2030_vcount", vcount, 2);
    check_eq("duty2030_period", last_p, 50);
    check_eq("duty2030_high", last_h, 20);

    // Lock onto 10, then hold low until timeout.
    clear_mon();
    base = cyc + 1;
    wave(5, 5, 3);
    rl = base + 20;
    check_eq("lock_vcount", vcount, 3);
    check_eq("lock_period", last_p, 10);
    while (cyc < rl + 101) step(1'b0);
    check_eq("to_before_nosig", int'(no_signal), 0);
    check_eq("to_before_period", int'(period_out), 10);
    step(1'b0);
    check_eq("to_nosig", int'(no_signal), 1);
    check_eq("to_period", int'(period_out), 0);
    check_eq("to_high", int'(high_out), 0);
    check_eq("to_no_valid", vcount, 3);

    // Restart: no_signal clears only at the second rise.
    clear_mon();
    base = cyc + 1;
    wave(5, 5, 1);
    step(1'b1);
    step(1'b1);
    check_eq("re_nosig_hold", int'(no_signal), 1);
    check_eq("re_vcount0", vcount, 0);
    step(1'b1);
    check_eq("re_valid_cyc", first_vcyc, base + 12);
    check_eq("re_nosig_clr", int'(no_signal), 0);
    check_eq("re_period", int'(period_out), 10);
    check_eq("re_high", int'(high_out), 5);
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);

    // Boundary: period exactly TIMEOUT is measured.
    clear_mon();
    wave(50, 50, 2);
    check_eq("b100_vcount", vcount, 2);
    check_eq("b100_period", last_p, 100);
    check_eq("b100_high", last_h, 50);
    check_eq("b100_nosig", int'(no_signal), 0);

    // Boundary: period TIMEOUT+1 times out with no valid.
    clear_mon();
    wave(50, 51, 1);
    for (int i = 0; i < 4; i++) step(1'b1);
    check_eq("b101_vcount", vcount, 1);
    check_eq("b101_last_period", last_p, 100);
    check_eq("b101_nosig", int'(no_signal), 1);
    check_eq("b101_period", int'(period_out), 0);

    // sig_in high across reset release must not arm.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1);
    rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 10; i++) step(1'b1);
    check_eq("hi_rel_vcount", vcount, 0);
    check_eq("hi_rel_nosig", int'(no_signal), 1);
    for (int i = 0; i < 4; i++) step(1'b0);
    wave(4, 4, 3);
    check_eq("p8_vcount", vcount, 2);
    check_eq("p8_period", last_p, 8);
    check_eq("p8_high", last_h, 4);
    check_eq("p8_nosig", int'(no_signal), 0);

    // Reset mid-period takes effect without a clock edge.
    step(1'b1);
    step(1'b1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_period", int'(period_out), 0);
    check_eq("mid_rst_high", int'(high_out), 0);
    check_eq("mid_rst_valid", int'(valid), 0);
    check_eq("mid_rst_nosig", int'(no_signal), 1);
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
